// File: rtl/ddr3_test_pkg.sv
// Shared DDR3 exerciser/checker definitions: checker FSM states, test patterns,
// addresses and user-side command codes.
package ddr3_test_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } rdchk_state_t;

  localparam logic [63:0] DATA1_1 = 64'h1AAA2AAA3AAA4AAA;
  localparam logic [63:0] DATA1_2 = 64'hE555D555C555B555;
  localparam logic [63:0] DATA2_1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] DATA2_2 = 64'hFEDCBA9876543210;

  localparam logic [27:0] ADDRESS1 = 28'h000_0100;
  localparam logic [27:0] ADDRESS2 = 28'h000_0200;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

endpackage

// File: rtl/ddr3_read_checker_if.sv
// Expected-data push side and core read-return side of the DDR3 read checker.
interface ddr3_read_checker_if #(
  parameter int DATA_W = 64
) ();
  logic              exp_push;
  logic [DATA_W-1:0] exp_data;
  logic              exp_full;
  logic [DATA_W-1:0] read_data;
  logic              read_data_valid;

  modport master (
    output exp_push, exp_data, read_data, read_data_valid,
    input  exp_full
  );

  modport slave (
    input  exp_push, exp_data, read_data, read_data_valid,
    output exp_full
  );
endinterface

// File: rtl/ddr3_rdchk_fifo.sv
// Synchronous first-word-fall-through FIFO holding expected read beats.
module ddr3_rdchk_fifo #(
  parameter int DATA_W     = 64,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = DEPTH[DEPTH_LOG2:0];

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  wr_en;
  logic                  rd_en;

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];
  assign rd_en = pop & ~empty;
  // a full FIFO still takes a push when the head leaves in the same cycle
  assign wr_en = push & (~full | rd_en);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ddr3_read_checker.sv
// Scores DDR3 read beats against an expected-data FIFO; counters, stickies, FSM.
// Define DDR3_RDCHK_CAPTURE_EN to add the first-mismatch capture outputs.
//   state  | meaning
//   S_IDLE | nothing pushed since rst/clr
//   S_RUN  | scoring returned beats
//   S_HALT | stopped after a mismatch (STOP_ON_ERR=1); left only by rst/clr
module ddr3_read_checker
  import ddr3_test_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int DEPTH_LOG2  = 3,
  parameter int CNT_W       = 16,
  parameter int STOP_ON_ERR = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  ddr3_read_checker_if.slave   bus,
  input  logic                 wl_err,
  output logic                 chk_pulse,
  output logic                 mismatch_pulse,
  output logic [CNT_W-1:0]     pass_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic                 err_sticky,
  output logic                 underflow,
  output logic                 overflow,
  output logic                 wl_err_sticky,
  output logic [1:0]           state
`ifdef DDR3_RDCHK_CAPTURE_EN
  ,
  output logic                 cap_valid,
  output logic [DATA_W-1:0]    cap_exp,
  output logic [DATA_W-1:0]    cap_got,
  output logic [CNT_W-1:0]     cap_idx
`endif
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  rdchk_state_t      st;
  logic [DATA_W-1:0] head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              sc_vld;
  logic [DATA_W-1:0] sc_got;
  logic [DATA_W-1:0] sc_exp;
  logic              score_en;
  logic              miss;

  assign pop          = bus.read_data_valid & ~fifo_empty & (st != S_HALT);
  assign bus.exp_full = fifo_full;
  assign state        = st;
  // a beat already in the pipeline when HALT is entered is not scored
  assign score_en     = sc_vld & (st != S_HALT);
  assign miss         = (sc_got != sc_exp);

  ddr3_rdchk_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (bus.exp_push),
    .din   (bus.exp_data),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      st             <= S_IDLE;
      sc_vld         <= 1'b0;
      sc_got         <= '0;
      sc_exp         <= '0;
      chk_pulse      <= 1'b0;
      mismatch_pulse <= 1'b0;
      pass_cnt       <= '0;
      err_cnt        <= '0;
      err_sticky     <= 1'b0;
      underflow      <= 1'b0;
      overflow       <= 1'b0;
      wl_err_sticky  <= 1'b0;
    end else begin
      sc_vld         <= pop;
      sc_got         <= bus.read_data;
      sc_exp         <= head;
      chk_pulse      <= score_en;
      mismatch_pulse <= score_en & miss;
      if (score_en) begin
        if (miss) begin
          err_sticky <= 1'b1;
          if (err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_ONE;
        end else if (pass_cnt != CNT_MAX) begin
          pass_cnt <= pass_cnt + CNT_ONE;
        end
      end
      if (bus.read_data_valid && fifo_empty) underflow <= 1'b1;
      if (bus.exp_push && fifo_full && !pop) overflow <= 1'b1;
      wl_err_sticky <= wl_err_sticky | wl_err;
      case (st)
        S_IDLE:  if (bus.exp_push) st <= S_RUN;
        S_RUN:   if (score_en && miss && (STOP_ON_ERR != 0)) st <= S_HALT;
        S_HALT:  st <= S_HALT;
        default: st <= S_IDLE;
      endcase
    end
  end

`ifdef DDR3_RDCHK_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cap_valid <= 1'b0;
      cap_exp   <= '0;
      cap_got   <= '0;
      cap_idx   <= '0;
    end else if (score_en && miss && !cap_valid) begin
      cap_valid <= 1'b1;
      cap_exp   <= sc_exp;
      cap_got   <= sc_got;
      cap_idx   <= pass_cnt + err_cnt;
    end
  end
`endif
endmodule

// File: tb/tb_ddr3_read_checker.sv
// Directed bench for ddr3_read_checker: main instance (CNT_W=4, keep scoring)
// plus a STOP_ON_ERR=1 instance for the halt behaviour.
module tb_ddr3_read_checker;
  import ddr3_test_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic wl_err = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   n_chk = 0;
  int   n_mis = 0;

  ddr3_read_checker_if #(.DATA_W(64)) bus ();
  ddr3_read_checker_if #(.DATA_W(64)) bus_h ();

  logic       chk_pulse, mismatch_pulse, err_sticky, underflow, overflow, wl_err_sticky;
  logic [3:0] pass_cnt, err_cnt;
  logic [1:0] state;
  logic       chk_pulse_h, mismatch_pulse_h, err_sticky_h, underflow_h, overflow_h, wl_err_sticky_h;
  logic [3:0] pass_cnt_h, err_cnt_h;
  logic [1:0] state_h;
`ifdef DDR3_RDCHK_CAPTURE_EN
  logic        cap_valid, cap_valid_h;
  logic [63:0] cap_exp, cap_got, cap_exp_h, cap_got_h;
  logic [3:0]  cap_idx, cap_idx_h;
`endif

  ddr3_read_checker #(.DATA_W(64), .DEPTH_LOG2(3), .CNT_W(4), .STOP_ON_ERR(0)) dut (
    .clk(clk), .rst(rst), .clr(clr), .bus(bus), .wl_err(wl_err),
    .chk_pulse(chk_pulse), .mismatch_pulse(mismatch_pulse),
    .pass_cnt(pass_cnt), .err_cnt(err_cnt), .err_sticky(err_sticky),
    .underflow(underflow), .overflow(overflow), .wl_err_sticky(wl_err_sticky),
    .state(state)
`ifdef DDR3_RDCHK_CAPTURE_EN
    , .cap_valid(cap_valid), .cap_exp(cap_exp), .cap_got(cap_got), .cap_idx(cap_idx)
`endif
  );

  ddr3_read_checker #(.DATA_W(64), .DEPTH_LOG2(3), .CNT_W(4), .STOP_ON_ERR(1)) dut_h (
    .clk(clk), .rst(rst), .clr(clr), .bus(bus_h), .wl_err(wl_err),
    .chk_pulse(chk_pulse_h), .mismatch_pulse(mismatch_pulse_h),
    .pass_cnt(pass_cnt_h), .err_cnt(err_cnt_h), .err_sticky(err_sticky_h),
    .underflow(underflow_h), .overflow(overflow_h), .wl_err_sticky(wl_err_sticky_h),
    .state(state_h)
`ifdef DDR3_RDCHK_CAPTURE_EN
    , .cap_valid(cap_valid_h), .cap_exp(cap_exp_h), .cap_got(cap_got_h), .cap_idx(cap_idx_h)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (chk_pulse) n_chk++;
    if (mismatch_pulse) n_mis++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] pat(int i);
    return {32'hC0DE0000 ^ 32'(i), 32'h0000BEEF + 32'(i)};
  endfunction

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr = 1'b0;
    wl_err = 1'b0;
    bus.exp_push = 1'b0;   bus.read_data_valid = 1'b0;
    bus.exp_data = '0;     bus.read_data = '0;
    bus_h.exp_push = 1'b0; bus_h.read_data_valid = 1'b0;
    bus_h.exp_data = '0;   bus_h.read_data = '0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic push_beat(input logic [63:0] d);
    bus.exp_push = 1'b1; bus.exp_data = d;
    tick();
    bus.exp_push = 1'b0;
  endtask

  task automatic read_beat(input logic [63:0] d);
    bus.read_data_valid = 1'b1; bus.read_data = d;
    tick();
    bus.read_data_valid = 1'b0;
  endtask

  task automatic push_read(input logic [63:0] pd, input logic [63:0] rd);
    bus.exp_push = 1'b1; bus.exp_data = pd;
    bus.read_data_valid = 1'b1; bus.read_data = rd;
    tick();
    bus.exp_push = 1'b0; bus.read_data_valid = 1'b0;
  endtask

  task automatic push_h(input logic [63:0] d);
    bus_h.exp_push = 1'b1; bus_h.exp_data = d;
    tick();
    bus_h.exp_push = 1'b0;
  endtask

  task automatic read_h(input logic [63:0] d);
    bus_h.read_data_valid = 1'b1; bus_h.read_data = d;
    tick();
    bus_h.read_data_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({err_sticky, underflow, overflow, wl_err_sticky, bus.exp_full, chk_pulse, mismatch_pulse} !== 7'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 0000000",
               {err_sticky, underflow, overflow, wl_err_sticky, bus.exp_full, chk_pulse, mismatch_pulse});
    end
    tests++;
    if ({pass_cnt, err_cnt} !== 8'h00) begin
      fails++; $display("FAIL reset_cnt: got %h expected 00", {pass_cnt, err_cnt});
    end
    tests++;
    if (state !== 2'b00) begin fails++; $display("FAIL reset_state: got %b expected 00", state); end
  endtask

  task automatic test_match();
    int c0, m0;
    do_reset();
    c0 = n_chk; m0 = n_mis;
    push_beat(DATA1_1);
    push_beat(DATA1_2);
    read_beat(DATA1_1);
    read_beat(DATA1_2);
    tick(3);
    tests++;
    if (n_chk - c0 !== 2) begin fails++; $display("FAIL match_chk_pulses: got %0d expected 2", n_chk - c0); end
    tests++;
    if (n_mis - m0 !== 0) begin fails++; $display("FAIL match_mis_pulses: got %0d expected 0", n_mis - m0); end
    tests++;
    if (pass_cnt !== 4'd2 || err_cnt !== 4'd0) begin
      fails++; $display("FAIL match_cnt: got pass %0d err %0d expected pass 2 err 0", pass_cnt, err_cnt);
    end
    tests++;
    if (state !== 2'b01) begin fails++; $display("FAIL match_state: got %b expected 01", state); end
  endtask

  task automatic test_mismatch();
    do_reset();
    push_beat(DATA2_1);
    read_beat(64'h0123456789ABCDEE);
    @(negedge clk);
    tests++;
    if (mismatch_pulse !== 1'b0) begin fails++; $display("FAIL mis_early: got %b expected 0", mismatch_pulse); end
    tick();
    tests++;
    if ({chk_pulse, mismatch_pulse} !== 2'b11) begin
      fails++; $display("FAIL mis_pulse: got %b expected 11", {chk_pulse, mismatch_pulse});
    end
    tests++;
    if (err_cnt !== 4'd1 || err_sticky !== 1'b1 || pass_cnt !== 4'd0) begin
      fails++;
      $display("FAIL mis_cnt: got err %0d sticky %b pass %0d expected 1 1 0", err_cnt, err_sticky, pass_cnt);
    end
    tick();
    tests++;
    if (mismatch_pulse !== 1'b0 || state !== 2'b01) begin
      fails++; $display("FAIL mis_after: got pulse %b state %b expected 0 01", mismatch_pulse, state);
    end
  endtask

  task automatic test_halt();
    do_reset();
    push_h(DATA2_1);
    push_h(DATA1_1);
    read_h(64'h0123456789ABCDEE);
    tick(2);
    tests++;
    if (state_h !== 2'b10 || err_cnt_h !== 4'd1) begin
      fails++; $display("FAIL halt_enter: got state %b err %0d expected 10 1", state_h, err_cnt_h);
    end
    read_h(DATA1_1);
    tick(3);
    tests++;
    if (pass_cnt_h !== 4'd0 || err_cnt_h !== 4'd1 || underflow_h !== 1'b0 || state_h !== 2'b10) begin
      fails++;
      $display("FAIL halt_noscore: got pass %0d err %0d uf %b state %b expected 0 1 0 10",
               pass_cnt_h, err_cnt_h, underflow_h, state_h);
    end
  endtask

  task automatic test_underflow();
    int c0;
    do_reset();
    c0 = n_chk;
    read_beat(DATA1_1);
    tick(3);
    tests++;
    if (underflow !== 1'b1 || pass_cnt !== 4'd0 || err_cnt !== 4'd0 || n_chk - c0 !== 0) begin
      fails++;
      $display("FAIL underflow: got uf %b pass %0d err %0d chk %0d expected 1 0 0 0",
               underflow, pass_cnt, err_cnt, n_chk - c0);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 9; i++) push_beat(pat(i));
    tests++;
    if (bus.exp_full !== 1'b1 || overflow !== 1'b1) begin
      fails++; $display("FAIL overflow_flag: got full %b ovf %b expected 1 1", bus.exp_full, overflow);
    end
    for (int i = 0; i < 8; i++) read_beat(pat(i));
    tick(3);
    tests++;
    if (pass_cnt !== 4'd8 || err_cnt !== 4'd0 || bus.exp_full !== 1'b0 || underflow !== 1'b0) begin
      fails++;
      $display("FAIL overflow_drain: got pass %0d err %0d full %b uf %b expected 8 0 0 0",
               pass_cnt, err_cnt, bus.exp_full, underflow);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 8; i++) push_beat(pat(i));
    push_read(pat(8), pat(0));
    tests++;
    if (bus.exp_full !== 1'b1 || overflow !== 1'b0) begin
      fails++; $display("FAIL fullpp_flags: got full %b ovf %b expected 1 0", bus.exp_full, overflow);
    end
    tick(3);
    tests++;
    if (pass_cnt !== 4'd1) begin fails++; $display("FAIL fullpp_score: got %0d expected 1", pass_cnt); end
    for (int i = 1; i < 9; i++) read_beat(pat(i));
    tick(3);
    tests++;
    if (pass_cnt !== 4'd9 || err_cnt !== 4'd0 || bus.exp_full !== 1'b0) begin
      fails++;
      $display("FAIL fullpp_drain: got pass %0d err %0d full %b expected 9 0 0", pass_cnt, err_cnt, bus.exp_full);
    end
  endtask

  task automatic test_wrap();
    int c0, m0;
    do_reset();
    c0 = n_chk; m0 = n_mis;
    push_beat(pat(100));
    for (int i = 0; i < 20; i++) push_read(pat(101 + i), pat(100 + i));
    read_beat(pat(120));
    tick(3);
    tests++;
    if (n_chk - c0 !== 21 || n_mis - m0 !== 0 || err_cnt !== 4'd0) begin
      fails++;
      $display("FAIL wrap: got chk %0d mis %0d err %0d expected 21 0 0", n_chk - c0, n_mis - m0, err_cnt);
    end
    tests++;
    if (pass_cnt !== 4'hF || underflow !== 1'b0) begin
      fails++; $display("FAIL wrap_sat: got pass %h uf %b expected f 0", pass_cnt, underflow);
    end
  endtask

  task automatic test_saturate_clr();
    int c0;
    do_reset();
    for (int i = 0; i < 19; i++) begin
      push_beat(pat(200 + i));
      read_beat(pat(200 + i));
    end
    tick(3);
    tests++;
    if (pass_cnt !== 4'hF || err_cnt !== 4'd0) begin
      fails++; $display("FAIL saturate: got pass %h err %h expected f 0", pass_cnt, err_cnt);
    end
    push_beat(pat(300));
    push_beat(pat(301));
    c0 = n_chk;
    read_beat(pat(300));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick(2);
    tests++;
    if (pass_cnt !== 4'd0 || state !== 2'b00 || n_chk - c0 !== 0 || err_sticky !== 1'b0) begin
      fails++;
      $display("FAIL clr: got pass %0d state %b chk %0d sticky %b expected 0 00 0 0",
               pass_cnt, state, n_chk - c0, err_sticky);
    end
    read_beat(pat(301));
    tick(2);
    tests++;
    if (underflow !== 1'b1 || pass_cnt !== 4'd0) begin
      fails++; $display("FAIL clr_flush: got uf %b pass %0d expected 1 0", underflow, pass_cnt);
    end
  endtask

  task automatic test_wl_err();
    do_reset();
    wl_err = 1'b1;
    tick();
    wl_err = 1'b0;
    tick(5);
    tests++;
    if (wl_err_sticky !== 1'b1) begin fails++; $display("FAIL wl_sticky: got %b expected 1", wl_err_sticky); end
    do_reset();
    tests++;
    if (wl_err_sticky !== 1'b0) begin fails++; $display("FAIL wl_reset: got %b expected 0", wl_err_sticky); end
  endtask

`ifdef DDR3_RDCHK_CAPTURE_EN
  task automatic test_capture();
    do_reset();
    push_beat(pat(400));
    push_beat(pat(401));
    push_beat(pat(402));
    read_beat(pat(400));
    read_beat(pat(401) ^ 64'h1);
    read_beat(pat(402) ^ 64'h2);
    tick(3);
    tests++;
    if (cap_valid !== 1'b1 || cap_idx !== 4'd1 || err_cnt !== 4'd2) begin
      fails++;
      $display("FAIL cap_idx: got valid %b idx %0d err %0d expected 1 1 2", cap_valid, cap_idx, err_cnt);
    end
    tests++;
    if (cap_exp !== pat(401) || cap_got !== (pat(401) ^ 64'h1)) begin
      fails++;
      $display("FAIL cap_data: got exp %h got %h expected %h %h", cap_exp, cap_got, pat(401), pat(401) ^ 64'h1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_halt();
    test_underflow();
    test_overflow();
    test_full_push_pop();
    test_wrap();
    test_saturate_clr();
    test_wl_err();
`ifdef DDR3_RDCHK_CAPTURE_EN
    test_capture();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
